writeback_unit: RTL and testbench

//   Initiator side of the register-file write port. Accepts MEM/WB results via a

---
 rtl/writeback_unit.sv | 145 ++++++++++++++
 tb/tb_writeback_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Writeback unit: accepts MEM/WB results over a valid/ready handshake,
// selects the result source, formats load data and drives the registered
// write port of the register file. Loads park the unit in WAIT_LOAD until
// the memory read data arrives.
module writeback_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [1:0]                i_result_src,
    input  logic [DATA_WIDTH-1:0]     i_alu_result,
    input  logic [DATA_WIDTH-1:0]     i_pc_plus4,
    input  logic [2:0]                i_funct3,
    input  logic                      i_mem_rdata_valid,
    input  logic [DATA_WIDTH-1:0]     i_mem_rdata,
    input  logic                      i_flush,
    output logic                      o_rd_write_en_wb,
    output logic [REG_ADDR_WIDTH-1:0] o_rd_addr_wb,
    output logic [DATA_WIDTH-1:0]     o_rd_data_wb,
    output logic                      o_busy,
    output logic                      o_retire
);

    typedef enum logic {
        IDLE,
        WAIT_LOAD
    } state_t;

    localparam logic [1:0] SRC_LOAD = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;

    state_t                    state;
    state_t                    next_state;
    logic                      accept;
    logic                      is_load;
    logic                      load_done;
    logic [REG_ADDR_WIDTH-1:0] lat_rd;
    logic                      lat_reg_write;
    logic [2:0]                lat_funct3;
    logic [1:0]                lat_off;
    logic [DATA_WIDTH-1:0]     direct_data;
    logic [DATA_WIDTH-1:0]     load_data;
    logic [7:0]                byte_sel;
    logic [15:0]               half_sel;

    assign o_ready   = (state == IDLE);
    assign o_busy    = (state == WAIT_LOAD);
    assign accept    = i_valid & o_ready & ~i_flush;
    assign is_load   = (i_result_src == SRC_LOAD);
    assign load_done = (state == WAIT_LOAD) & ~i_flush & i_mem_rdata_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush takes priority over arriving read data
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && is_load) begin
                    next_state = WAIT_LOAD;
                end
            end
            WAIT_LOAD: begin
                if (i_flush || i_mem_rdata_valid) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Non-load result selection (11 behaves as ALU)
    always_comb begin
        direct_data = i_alu_result;
        if (i_result_src == SRC_PC4) begin
            direct_data = i_pc_plus4;
        end
    end

    // Extract the addressed byte/half of the memory word and extend it
    always_comb begin
        byte_sel  = i_mem_rdata[8*lat_off +: 8];
        half_sel  = i_mem_rdata[16*lat_off[1] +: 16];
        load_data = i_mem_rdata;
        case (lat_funct3)
            3'b000:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            3'b001:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_data = i_mem_rdata;
        endcase
    end

    // Capture the load's destination and format info when it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_rd        <= '0;
            lat_reg_write <= 1'b0;
            lat_funct3    <= 3'b000;
            lat_off       <= 2'b00;
        end else if (accept && is_load) begin
            lat_rd        <= i_rd_addr;
            lat_reg_write <= i_reg_write;
            lat_funct3    <= i_funct3;
            lat_off       <= i_alu_result[1:0];
        end
    end

    // Registered write port; addr/data only change when an instruction retires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_write_en_wb <= 1'b0;
            o_rd_addr_wb     <= '0;
            o_rd_data_wb     <= '0;
            o_retire         <= 1'b0;
        end else begin
            o_rd_write_en_wb <= 1'b0;
            o_retire         <= 1'b0;
            if (accept && !is_load) begin
                o_rd_write_en_wb <= i_reg_write & (i_rd_addr != '0);
                o_rd_addr_wb     <= i_rd_addr;
                o_rd_data_wb     <= direct_data;
                o_retire         <= 1'b1;
            end else if (load_done) begin
                o_rd_write_en_wb <= lat_reg_write & (lat_rd != '0);
                o_rd_addr_wb     <= lat_rd;
                o_rd_data_wb     <= load_data;
                o_retire         <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_reg_write;
    logic [4:0]  i_rd_addr;
    logic [1:0]  i_result_src;
    logic [31:0] i_alu_result;
    logic [31:0] i_pc_plus4;
    logic [2:0]  i_funct3;
    logic        i_mem_rdata_valid;
    logic [31:0] i_mem_rdata;
    logic        i_flush;
    logic        o_rd_write_en_wb;
    logic [4:0]  o_rd_addr_wb;
    logic [31:0] o_rd_data_wb;
    logic        o_busy;
    logic        o_retire;

    int checks = 0;
    int errors = 0;

    writeback_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_reg_write       (i_reg_write),
        .i_rd_addr         (i_rd_addr),
        .i_result_src      (i_result_src),
        .i_alu_result      (i_alu_result),
        .i_pc_plus4        (i_pc_plus4),
        .i_funct3          (i_funct3),
        .i_mem_rdata_valid (i_mem_rdata_valid),
        .i_mem_rdata       (i_mem_rdata),
        .i_flush           (i_flush),
        .o_rd_write_en_wb  (o_rd_write_en_wb),
        .o_rd_addr_wb      (o_rd_addr_wb),
        .o_rd_data_wb      (o_rd_data_wb),
        .o_busy            (o_busy),
        .o_retire          (o_retire)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic reg_write, input logic [4:0] rd,
                                 input logic [1:0] src, input logic [31:0] alu, input logic [31:0] pc4,
                                 input logic [2:0] f3, input logic rvalid, input logic [31:0] rdata,
                                 input logic flush);
        i_valid           = valid;
        i_reg_write       = reg_write;
        i_rd_addr         = rd;
        i_result_src      = src;
        i_alu_result      = alu;
        i_pc_plus4        = pc4;
        i_funct3          = f3;
        i_mem_rdata_valid = rvalid;
        i_mem_rdata       = rdata;
        i_flush           = flush;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b000, 0, 32'h0, 0);
    endtask

    // Advance one clock and sample 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load: accept, a single wait cycle, then data arrives
    task automatic run_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] rdata, input logic [31:0] expected);
        applyStimulus(1, 1, rd, 2'b01, {30'h400, off}, 32'h0, f3, 0, 32'h0, 0);
        tick();
        checkOutput({tag, "_ready_wait"}, {31'b0, o_ready}, 32'd0);
        checkOutput({tag, "_busy_wait"}, {31'b0, o_busy}, 32'd1);
        idle();
        tick();
        checkOutput({tag, "_en_wait"}, {31'b0, o_rd_write_en_wb}, 32'd0);
        applyStimulus(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b000, 1, rdata, 0);
        tick();
        checkOutput({tag, "_en"}, {31'b0, o_rd_write_en_wb}, 32'd1);
        checkOutput({tag, "_addr"}, {27'b0, o_rd_addr_wb}, {27'b0, rd});
        checkOutput({tag, "_data"}, o_rd_data_wb, expected);
        checkOutput({tag, "_retire"}, {31'b0, o_retire}, 32'd1);
        idle();
    endtask

    initial begin
        $display("[TB] writeback_unit directed test start");
        rst_n = 1'b0;
        idle();
        tick();
        tick();
        checkOutput("rst_ready", {31'b0, o_ready}, 32'd1);
        checkOutput("rst_busy", {31'b0, o_busy}, 32'd0);
        checkOutput("rst_en", {31'b0, o_rd_write_en_wb}, 32'd0);
        checkOutput("rst_addr", {27'b0, o_rd_addr_wb}, 32'd0);
        checkOutput("rst_data", o_rd_data_wb, 32'd0);
        checkOutput("rst_retire", {31'b0, o_retire}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU write, one-cycle latency
        applyStimulus(1, 1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 3'b000, 0, 32'h0, 0);
        tick();
        checkOutput("alu_en", {31'b0, o_rd_write_en_wb}, 32'd1);
        checkOutput("alu_addr", {27'b0, o_rd_addr_wb}, 32'd5);
        checkOutput("alu_data", o_rd_data_wb, 32'hDEADBEEF);
        checkOutput("alu_retire", {31'b0, o_retire}, 32'd1);
        idle();
        tick();
        checkOutput("alu_en_drop", {31'b0, o_rd_write_en_wb}, 32'd0);
        checkOutput("alu_retire_drop", {31'b0, o_retire}, 32'd0);
        checkOutput("alu_addr_hold", {27'b0, o_rd_addr_wb}, 32'd5);
        checkOutput("alu_data_hold", o_rd_data_wb, 32'hDEADBEEF);

        // Load formatting
        run_load("lb", 5'd7, 3'b000, 2'd3, 32'h80112233, 32'hFFFFFF80);
        run_load("lbu", 5'd8, 3'b100, 2'd3, 32'h80112233, 32'h00000080);
        run_load("lh", 5'd9, 3'b001, 2'd2, 32'h80011234, 32'hFFFF8001);
        run_load("lhu", 5'd10, 3'b101, 2'd0, 32'h80011234, 32'h00001234);
        run_load("lw", 5'd11, 3'b010, 2'd0, 32'h80011234, 32'h80011234);
        run_load("lb_off1", 5'd12, 3'b000, 2'd1, 32'h80112233, 32'h00000022);
        run_load("lhu_off3", 5'd13, 3'b101, 2'd3, 32'h80011234, 32'h00008001);
        run_load("f3_111_lw", 5'd14, 3'b111, 2'd2, 32'hCAFEF00D, 32'hCAFEF00D);

        // Read data in IDLE is ignored
        applyStimulus(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b000, 1, 32'h12345678, 0);
        tick();
        checkOutput("idle_rvalid_retire", {31'b0, o_retire}, 32'd0);
        checkOutput("idle_rvalid_data", o_rd_data_wb, 32'hCAFEF00D);

        // Flush in IDLE suppresses the accept
        applyStimulus(1, 1, 5'd3, 2'b00, 32'h11111111, 32'h0, 3'b000, 0, 32'h0, 1);
        tick();
        checkOutput("idle_flush_en", {31'b0, o_rd_write_en_wb}, 32'd0);
        checkOutput("idle_flush_retire", {31'b0, o_retire}, 32'd0);

        // PC+4 to x1 then ALU to x0, back to back
        applyStimulus(1, 1, 5'd1, 2'b10, 32'h55555555, 32'h00000104, 3'b000, 0, 32'h0, 0);
        tick();
        checkOutput("pc4_en", {31'b0, o_rd_write_en_wb}, 32'd1);
        checkOutput("pc4_addr", {27'b0, o_rd_addr_wb}, 32'd1);
        checkOutput("pc4_data", o_rd_data_wb, 32'h00000104);
        checkOutput("pc4_ready", {31'b0, o_ready}, 32'd1);
        applyStimulus(1, 1, 5'd0, 2'b00, 32'h77777777, 32'h0, 3'b000, 0, 32'h0, 0);
        tick();
        checkOutput("x0_en", {31'b0, o_rd_write_en_wb}, 32'd0);
        checkOutput("x0_retire", {31'b0, o_retire}, 32'd1);

        // Source 11 behaves as ALU; reg_write=0 still retires without a write
        applyStimulus(1, 1, 5'd4, 2'b11, 32'h0000ABCD, 32'h00000200, 3'b000, 0, 32'h0, 0);
        tick();
        checkOutput("src11_data", o_rd_data_wb, 32'h0000ABCD);
        checkOutput("src11_en", {31'b0, o_rd_write_en_wb}, 32'd1);
        applyStimulus(1, 0, 5'd6, 2'b00, 32'h00000042, 32'h0, 3'b000, 0, 32'h0, 0);
        tick();
        checkOutput("nowr_en", {31'b0, o_rd_write_en_wb}, 32'd0);
        checkOutput("nowr_retire", {31'b0, o_retire}, 32'd1);
        idle();
        tick();

        // Load, three wait cycles, flush together with read data
        applyStimulus(1, 1, 5'd15, 2'b01, 32'h00000400, 32'h0, 3'b010, 0, 32'h0, 0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("flush_wait_busy", {31'b0, o_busy}, 32'd1);
        end
        applyStimulus(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b000, 1, 32'h99999999, 1);
        tick();
        checkOutput("flush_en", {31'b0, o_rd_write_en_wb}, 32'd0);
        checkOutput("flush_retire", {31'b0, o_retire}, 32'd0);
        checkOutput("flush_ready", {31'b0, o_ready}, 32'd1);
        idle();
        tick();
        checkOutput("flush_retire_after", {31'b0, o_retire}, 32'd0);

        // Asynchronous reset while waiting for load data
        applyStimulus(1, 1, 5'd16, 2'b01, 32'h00000400, 32'h0, 3'b010, 0, 32'h0, 0);
        tick();
        idle();
        checkOutput("arst_pre_busy", {31'b0, o_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", {31'b0, o_busy}, 32'd0);
        checkOutput("arst_ready", {31'b0, o_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        applyStimulus(0, 0, 5'd0, 2'b00, 32'h0, 32'h0, 3'b000, 1, 32'hAAAAAAAA, 0);
        tick();
        checkOutput("arst_en", {31'b0, o_rd_write_en_wb}, 32'd0);
        checkOutput("arst_retire", {31'b0, o_retire}, 32'd0);
        checkOutput("arst_ready_after", {31'b0, o_ready}, 32'd1);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
